cellrv32_cpu_regfile_mp: RTL and testbench



---
 rtl/cellrv32_cpu_regfile_mp.sv | 171 +++++++++++++++++
 tb/tb_cellrv32_cpu_regfile_mp.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cellrv32_cpu_regfile_mp.sv
// cellrv32_cpu_regfile_mp
// Multi-port general-purpose register file for the CELLRV32 core: one write
// port, NUM_RD synchronous read ports, a hardware clear sequencer that zeroes
// every entry after reset, and a per-register pending-write scoreboard.
// Optional feature macro: CELLRV32_RF_BYPASS_EN (write-first forwarding on the
// read ports and on the scoreboard outputs). Undefined = read-first.
module cellrv32_cpu_regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [4:0]             waddr_i,
    input  logic [XLEN-1:0]        wdata_i,
    input  logic [NUM_RD-1:0]      re_i,
    input  logic [5*NUM_RD-1:0]    raddr_i,
    output logic [XLEN*NUM_RD-1:0] rdata_o,
    input  logic                   sb_set_i,
    input  logic [4:0]             sb_addr_i,
    output logic [NUM_RD-1:0]      sb_pend_o,
    output logic                   busy_o
);

    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_cnt_q, clr_cnt_d;
    logic [XLEN-1:0]     mem [NUM_REGS];
    logic [NUM_REGS-1:0] sb_q;

    logic [AW-1:0]       waddr;
    logic [AW-1:0]       sb_addr;
    logic [AW-1:0]       raddr [NUM_RD];
    logic [XLEN-1:0]     rd_val [NUM_RD];

    logic                ready;
    logic                clearing;
    logic                wr_acc;
    logic                sb_set_acc;
    logic                mem_we;
    logic [AW-1:0]       mem_wa;
    logic [XLEN-1:0]     mem_wd;

    // Upper address bits are ignored when the file has fewer than 32 entries.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{waddr_i, raddr_i, sb_addr_i};

    assign waddr   = waddr_i[AW-1:0];
    assign sb_addr = sb_addr_i[AW-1:0];

    // Per-port address decode (only the low AW bits select an entry)
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            raddr[k] = raddr_i[5*k +: AW];
        end
    end

    // Reset cycles count as clear cycles: no writes, no scoreboard updates
    assign ready      = (state_q == READY) && !rst_i;
    assign clearing   = (state_q == CLEAR) && !rst_i;
    assign wr_acc     = ready && we_i && (waddr != '0);
    assign sb_set_acc = ready && sb_set_i && (sb_addr != '0);
    assign busy_o     = rst_i || (state_q == CLEAR);

    // Clear sequencer state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Clear sequencer next state: walk every entry once, then go READY
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Single physical write port shared by the clear sequencer and the CPU
    assign mem_we = clearing || wr_acc;
    assign mem_wa = clearing ? clr_cnt_q : waddr;
    assign mem_wd = clearing ? '0 : wdata_i;

    // Storage array: no reset, contents defined by the clear sequence
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    // Read value selection per port (x0 hard-wired to zero)
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_val[k] = mem[raddr[k]];
`ifdef CELLRV32_RF_BYPASS_EN
            if (wr_acc && (waddr == raddr[k])) begin
                rd_val[k] = wdata_i;
            end
`endif
            if (raddr[k] == '0) begin
                rd_val[k] = '0;
            end
        end
    end

    // Registered read ports; held at zero while clearing, hold when not enabled
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == CLEAR)) begin
            rdata_o <= '0;
        end else begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (re_i[k]) begin
                    rdata_o[XLEN*k +: XLEN] <= rd_val[k];
                end
            end
        end
    end

    // Pending-write scoreboard: a write clears its bit, a set (applied last) wins
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sb_q <= '0;
        end else begin
            if (wr_acc) begin
                sb_q[waddr] <= 1'b0;
            end
            if (sb_set_acc) begin
                sb_q[sb_addr] <= 1'b1;
            end
        end
    end

    // Pending flag per read port, looked up from the registered bits
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            sb_pend_o[k] = (raddr[k] != '0) && sb_q[raddr[k]];
`ifdef CELLRV32_RF_BYPASS_EN
            if (wr_acc && (waddr == raddr[k]) &&
                !(sb_set_acc && (sb_addr == raddr[k]))) begin
                sb_pend_o[k] = 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_cellrv32_cpu_regfile_mp.sv
// Directed testbench for cellrv32_cpu_regfile_mp: a default 32x32, two-port
// instance plus a 16-entry, four-port instance for the narrow-address case.
module tb_cellrv32_cpu_regfile_mp;

    logic         clk;
    int           checks;
    int           errors;

    // Default configuration instance (32 entries, 2 read ports)
    logic         rst, we, sb_set, busy;
    logic [4:0]   waddr, sb_addr;
    logic [31:0]  wdata;
    logic [1:0]   re, sb_pend;
    logic [9:0]   raddr;
    logic [63:0]  rdata;

    // Narrow configuration instance (16 entries, 4 read ports)
    logic         rst16, we16, sb_set16, busy16;
    logic [4:0]   waddr16, sb_addr16;
    logic [31:0]  wdata16;
    logic [3:0]   re16, sb_pend16;
    logic [19:0]  raddr16;
    logic [127:0] rdata16;

    cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RD(2)) dut (
        .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .sb_set_i(sb_set),
        .sb_addr_i(sb_addr), .sb_pend_o(sb_pend), .busy_o(busy)
    );

    cellrv32_cpu_regfile_mp #(.XLEN(32), .NUM_REGS(16), .NUM_RD(4)) dut16 (
        .clk_i(clk), .rst_i(rst16), .we_i(we16), .waddr_i(waddr16), .wdata_i(wdata16),
        .re_i(re16), .raddr_i(raddr16), .rdata_o(rdata16), .sb_set_i(sb_set16),
        .sb_addr_i(sb_addr16), .sb_pend_o(sb_pend16), .busy_o(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
        checks++;
        if (rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++;
        if (sb_pend !== 2'b00) begin errors++; $display("FAIL reset_sb_pend got %b exp 00", sb_pend); end
        rst = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 32) begin errors++; $display("FAIL reset_clear_len got %0d exp 32", n); end
        re = 2'b11;
        for (int i = 0; i < 32; i++) begin
            raddr = {i[4:0], i[4:0]};
            tick();
            checks++;
            if (rdata !== 64'h0) begin
                errors++;
                $display("FAIL reset_entry_zero x%0d got %h exp 0", i, rdata);
            end
        end
        re = 2'b00;
    endtask

    task automatic test_write_read();
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        tick();
        we = 1'b0;
        re = 2'b11; raddr = {5'd5, 5'd5};
        tick();
        checks++;
        if (rdata[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_p0_x5 got %h exp deadbeef", rdata[31:0]); end
        checks++;
        if (rdata[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_p1_x5 got %h exp deadbeef", rdata[63:32]); end
        // disabled ports hold their previous value
        re = 2'b00; raddr = 10'h0;
        tick();
        checks++;
        if (rdata !== 64'hDEADBEEF_DEADBEEF) begin errors++; $display("FAIL rd_hold got %h exp deadbeefdeadbeef", rdata); end
        we = 1'b1; waddr = 5'd0; wdata = 32'h00001234;
        tick();
        we = 1'b0;
        re = 2'b11; raddr = 10'h0;
        tick();
        checks++;
        if (rdata !== 64'h0) begin errors++; $display("FAIL wr_x0 got %h exp 0", rdata); end
        re = 2'b00;
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
`ifdef CELLRV32_RF_BYPASS_EN
        exp = 32'hA5A5A5A5;
`else
        exp = 32'h00000011;
`endif
        we = 1'b1; waddr = 5'd7; wdata = 32'h00000011;
        tick();
        wdata = 32'hA5A5A5A5;
        re = 2'b01; raddr = {5'd0, 5'd7};
        tick();
        we = 1'b0;
        checks++;
        if (rdata[31:0] !== exp) begin errors++; $display("FAIL bypass_same_cycle got %h exp %h", rdata[31:0], exp); end
        tick();
        checks++;
        if (rdata[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next_cycle got %h exp a5a5a5a5", rdata[31:0]); end
        re = 2'b00;
    endtask

    task automatic test_scoreboard();
        raddr = {5'd9, 5'd0};
        checks++;
        if (sb_pend !== 2'b00) begin errors++; $display("FAIL sb_idle got %b exp 00", sb_pend); end
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        sb_set = 1'b0;
        checks++;
        if (sb_pend !== 2'b10) begin errors++; $display("FAIL sb_set_x9 got %b exp 10", sb_pend); end
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        tick();
        we = 1'b0;
        checks++;
        if (sb_pend !== 2'b00) begin errors++; $display("FAIL sb_clear_x9 got %b exp 00", sb_pend); end
        sb_set = 1'b1; sb_addr = 5'd9; we = 1'b1; waddr = 5'd9;
        tick();
        sb_set = 1'b0; we = 1'b0;
        checks++;
        if (sb_pend !== 2'b10) begin errors++; $display("FAIL sb_set_wins got %b exp 10", sb_pend); end
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        sb_set = 1'b0;
        checks++;
        if (sb_pend !== 2'b10) begin errors++; $display("FAIL sb_x0_ignored got %b exp 10", sb_pend); end
        we = 1'b1; waddr = 5'd9;
        tick();
        we = 1'b0;
        checks++;
        if (sb_pend !== 2'b00) begin errors++; $display("FAIL sb_clear_again got %b exp 00", sb_pend); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        we = 1'b1; waddr = 5'd20; wdata = 32'hCAFEF00D;
        tick();
        we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        re = 2'b01; raddr = {5'd0, 5'd20};
        tick();
        checks++;
        if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL clear_read_zero got %h exp 0", rdata[31:0]); end
        re = 2'b00;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we = 1'b1; waddr = 5'd1; wdata = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_addr = 5'd1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        we = 1'b0; sb_set = 1'b0;
        checks++;
        if (n != 32) begin errors++; $display("FAIL midclear_len got %0d exp 32", n); end
        re = 2'b11; raddr = {5'd20, 5'd1};
        tick();
        checks++;
        if (rdata[31:0] !== 32'h0) begin errors++; $display("FAIL busy_write_dropped got %h exp 0", rdata[31:0]); end
        checks++;
        if (rdata[63:32] !== 32'h0) begin errors++; $display("FAIL midclear_x20_zero got %h exp 0", rdata[63:32]); end
        checks++;
        if (sb_pend !== 2'b00) begin errors++; $display("FAIL busy_sb_dropped got %b exp 00", sb_pend); end
        re = 2'b00;
    endtask

    task automatic test_narrow();
        int n;
        rst16 = 1'b1;
        tick();
        rst16 = 1'b0;
        n = 0;
        while (busy16 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin errors++; $display("FAIL narrow_clear_len got %0d exp 16", n); end
        we16 = 1'b1; waddr16 = 5'h13; wdata16 = 32'h5A5A1234;
        tick();
        we16 = 1'b0;
        re16 = 4'hF; raddr16 = {5'h13, 5'd3, 5'd3, 5'd3};
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdata16[32*k +: 32] !== 32'h5A5A1234) begin
                errors++;
                $display("FAIL narrow_port%0d got %h exp 5a5a1234", k, rdata16[32*k +: 32]);
            end
        end
        re16 = 4'h0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; re = '0; raddr = '0;
        sb_set = 1'b0; sb_addr = '0;
        rst16 = 1'b0; we16 = 1'b0; waddr16 = '0; wdata16 = '0; re16 = '0; raddr16 = '0;
        sb_set16 = 1'b0; sb_addr16 = '0;
        #3;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_reset_mid_clear();
        test_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
